// File: rtl/dff_delay_line_param.sv
// Parametrised multi-bit delay line with runtime tap select, stall, sync clear,
// per-stage valid tracking, fill status and out-of-range select flag.
module dff_delay_line_param #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      MAX_DEPTH   = 16,
    parameter int unsigned      SEL_W       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] delay_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             primed,
    output logic             sel_err
);

    localparam int unsigned      IDX_W    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(MAX_DEPTH + 1);
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(MAX_DEPTH - 1);
    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(MAX_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_DEPTH);

    logic [WIDTH-1:0]     stage_q [MAX_DEPTH];
    logic [WIDTH-1:0]     stage_d [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]     fill_q, fill_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic                 sel_err_q, sel_err_d;

    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        fill_d  = fill_q;
        if (clr) begin
            for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
                stage_d[i] = RESET_VALUE;
            end
            vld_d  = '0;
            fill_d = '0;
        end else if (en) begin
            stage_d[0] = in_data;
            for (int unsigned i = 1; i < MAX_DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            vld_d = {vld_q[MAX_DEPTH-2:0], in_valid};
            if (fill_q != FULL_CNT) begin
                fill_d = fill_q + CNT_W'(1);
            end
        end
    end

    // Tap select tracks delay_sel every edge, regardless of en/clr; kept in
    // index width since the clamped value always fits.
    always_comb begin
        sel_err_d = (delay_sel > MAX_SEL);
        sel_d     = sel_err_d ? MAX_IDX : delay_sel[IDX_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
            vld_q     <= '0;
            fill_q    <= '0;
            sel_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            vld_q     <= vld_d;
            fill_q    <= fill_d;
            sel_q     <= sel_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign out_data  = stage_q[sel_q];
    assign out_valid = vld_q[sel_q];
    assign primed    = (32'(fill_q) > 32'(sel_q));
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_dff_delay_line_param.sv
// Directed + randomized bench for dff_delay_line_param against a sample-history model.
module tb_dff_delay_line_param;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_DEPTH = 16;
    localparam int unsigned SEL_W     = 5;

    logic             CLK = 1'b0;
    logic             RST;
    logic             en, clr, in_valid;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] delay_sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid, primed, sel_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: newest-first history of accepted {valid,data} samples since last clear.
    logic [WIDTH:0] hist[$];
    int unsigned    tap_m = 0;
    logic           err_m = 1'b0;

    dff_delay_line_param #(
        .WIDTH      (WIDTH),
        .MAX_DEPTH  (MAX_DEPTH),
        .SEL_W      (SEL_W),
        .RESET_VALUE('0)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .en       (en),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .delay_sel(delay_sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .primed   (primed),
        .sel_err  (sel_err)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        hist.delete();
        tap_m = 0;
        err_m = 1'b0;
    endtask

    task automatic check(input string tag);
        logic [WIDTH:0] exp_s;
        logic           exp_p;
        exp_s = (tap_m < hist.size()) ? hist[tap_m] : '0;
        exp_p = (hist.size() > tap_m);
        checks++;
        assert (out_data === exp_s[WIDTH-1:0]) else begin
            errors++;
            $error("FAIL %s out_data got %0h exp %0h", tag, out_data, exp_s[WIDTH-1:0]);
        end
        checks++;
        assert (out_valid === exp_s[WIDTH]) else begin
            errors++;
            $error("FAIL %s out_valid got %0b exp %0b", tag, out_valid, exp_s[WIDTH]);
        end
        checks++;
        assert (primed === exp_p) else begin
            errors++;
            $error("FAIL %s primed got %0b exp %0b", tag, primed, exp_p);
        end
        checks++;
        assert (sel_err === err_m) else begin
            errors++;
            $error("FAIL %s sel_err got %0b exp %0b", tag, sel_err, err_m);
        end
    endtask

    task automatic check_data(input string tag, input logic [WIDTH-1:0] exp);
        checks++;
        assert (out_data === exp) else begin
            errors++;
            $error("FAIL %s out_data got %0h exp %0h", tag, out_data, exp);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
    task automatic step(input logic e, input logic c, input logic v,
                        input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s,
                        input string tag);
        @(negedge CLK);
        en = e; clr = c; in_valid = v; in_data = d; delay_sel = s;
        @(posedge CLK);
        if (c) begin
            hist.delete();
        end else if (e) begin
            hist.push_front({v, d});
            if (hist.size() > MAX_DEPTH) void'(hist.pop_back());
        end
        err_m = (int'(s) > MAX_DEPTH - 1);
        tap_m = err_m ? MAX_DEPTH - 1 : int'(s);
        #1;
        check(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] pat [5];
        pat = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0};
        RST = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; delay_sel = '0;
        model_reset();
        #12;
        check("reset_held");
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0, '0, "idle");

        // Legacy 4-stage equivalence on bit 0
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, pat[i], 5'd3, "legacy");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'd0, 5'd3, "legacy_tail");

        // Stall does not count toward delay
        step(1'b0, 1'b1, 1'b0, '0, 5'd2, "stall_clr");
        step(1'b1, 1'b0, 1'b1, 8'hA1, 5'd2, "stall_a1");
        step(1'b1, 1'b0, 1'b1, 8'hA2, 5'd2, "stall_a2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'hEE, 5'd2, "stall_hold");
        step(1'b1, 1'b0, 1'b1, 8'hA3, 5'd2, "stall_a3");
        check_data("stall_a1_out", 8'hA1);

        // Clear wins over enable; the 0xFF sample is dropped
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b1, 8'h55, 5'd15, "fill55");
        step(1'b1, 1'b1, 1'b1, 8'hFF, 5'd15, "clr_pri");
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 5'd15, "post_clr");

        // Tap change and clamp
        step(1'b0, 1'b1, 1'b0, '0, 5'd3, "tap_clr");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 5'd3, "tap3");
        check_data("tap3_diff", 8'd16);
        for (int i = 20; i < 24; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 5'd7, "tap7");
        check_data("tap7_diff", 8'd16);
        step(1'b1, 1'b0, 1'b1, 8'd24, 5'd20, "tap_clamp");
        check_data("tap_clamp_diff", 8'd9);

        // Asynchronous reset between edges
        step(1'b1, 1'b0, 1'b1, 8'h77, 5'd0, "pre_arst");
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        check("async_rst");
        @(negedge CLK);
        RST = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [SEL_W-1:0] s;
            s = ($urandom_range(0, 7) == 0) ? SEL_W'($urandom_range(16, 31))
                                             : SEL_W'($urandom_range(0, 15));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 1'($urandom), 8'($urandom), s, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
